maria_dma_arbiter: RTL and testbench



---
 rtl/maria_dma_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_maria_dma_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maria_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : maria_dma_arbiter
// Brief    : Hands the Maria address bus between the 6502 (SALLY) and the
//            Maria DMA engine. A DMA request halts the CPU, waits for the
//            current CPU cycle to end plus a settle interval, grants the bus,
//            enforces a per-burst mclk1 budget and releases the CPU on mclk0.
// Revision : 1.0 - initial release
// ============================================================================
module maria_dma_arbiter #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int MAX_DMA_CYCLES = 400,
  parameter int CNT_W          = 9
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             mclk0,
  input  logic             mclk1,
  input  logic             pclk1,
  input  logic             dma_en,
  input  logic             line_start,
  input  logic             dma_req,
  input  logic             dma_done,
  output logic             halt_n,
  output logic             drive_AB,
  output logic             dma_grant,
  output logic [CNT_W-1:0] dma_cycles,
  output logic             overrun
);

  // Settle counter only needs to reach SETTLE_CYCLES.
  localparam int                 c_SET_W       = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [c_SET_W-1:0] c_SETTLE_LAST = c_SET_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]   c_MAX_CYCLES  = CNT_W'(MAX_DMA_CYCLES);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_HALT_REQ = 3'd1;
  localparam logic [2:0] c_SETTLE   = 3'd2;
  localparam logic [2:0] c_GRANT    = 3'd3;
  localparam logic [2:0] c_RELEASE  = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;

  logic               r_halt_n;
  logic               r_drive_ab;
  logic               r_dma_grant;
  logic [CNT_W-1:0]   r_dma_cycles;
  logic               r_overrun;
  logic [c_SET_W-1:0] r_settle_cnt;

  logic               w_halt_n_nxt;
  logic               w_drive_ab_nxt;
  logic               w_dma_grant_nxt;
  logic [CNT_W-1:0]   w_dma_cycles_nxt;
  logic               w_overrun_nxt;
  logic [c_SET_W-1:0] w_settle_cnt_nxt;

  logic               w_run_ok;
  logic [c_SET_W-1:0] w_settle_inc;
  logic               w_settle_done;
  logic [CNT_W-1:0]   w_cycles_inc;
  logic               w_budget_hit;
  logic               w_grant_release;
  logic               w_overrun_set;

  // A request is live only while DMA is globally enabled.
  assign w_run_ok        = dma_req && dma_en;
  assign w_settle_inc    = r_settle_cnt + c_SET_W'(1);
  assign w_settle_done   = mclk1 && (w_settle_inc >= c_SETTLE_LAST);
  assign w_cycles_inc    = r_dma_cycles + CNT_W'(1);
  // Budget is exhausted on the mclk1 that brings the count to the limit.
  assign w_budget_hit    = mclk1 && (w_cycles_inc >= c_MAX_CYCLES);
  assign w_grant_release = dma_done || w_budget_hit || !dma_en;
  // A coincident dma_done makes the release a normal one.
  assign w_overrun_set   = (r_state == c_GRANT) && w_budget_hit && !dma_done;

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; aborts take priority over the advancing strobe.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_run_ok) w_state_nxt = c_HALT_REQ;
      end
      c_HALT_REQ: begin
        if (!w_run_ok)  w_state_nxt = c_RELEASE;
        else if (pclk1) w_state_nxt = c_SETTLE;
      end
      c_SETTLE: begin
        if (!dma_en)            w_state_nxt = c_RELEASE;
        else if (w_settle_done) w_state_nxt = c_GRANT;
      end
      c_GRANT: begin
        if (w_grant_release) w_state_nxt = c_RELEASE;
      end
      c_RELEASE: begin
        if (mclk0) w_state_nxt = c_IDLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and counters.
  always_comb begin
    w_halt_n_nxt     = r_halt_n;
    w_drive_ab_nxt   = r_drive_ab;
    w_dma_grant_nxt  = r_dma_grant;
    w_dma_cycles_nxt = r_dma_cycles;
    w_settle_cnt_nxt = r_settle_cnt;
    case (r_state)
      c_IDLE: begin
        if (w_run_ok) w_halt_n_nxt = 1'b0;
      end
      c_HALT_REQ: begin
        if (w_run_ok && pclk1) w_settle_cnt_nxt = '0;
      end
      c_SETTLE: begin
        if (dma_en && mclk1) begin
          w_settle_cnt_nxt = w_settle_inc;
          if (w_settle_done) begin
            w_drive_ab_nxt   = 1'b1;
            w_dma_grant_nxt  = 1'b1;
            w_dma_cycles_nxt = '0;
          end
        end
      end
      c_GRANT: begin
        if (mclk1 && (r_dma_cycles < c_MAX_CYCLES)) w_dma_cycles_nxt = w_cycles_inc;
        if (w_grant_release) begin
          w_drive_ab_nxt  = 1'b0;
          w_dma_grant_nxt = 1'b0;
        end
      end
      c_RELEASE: begin
        if (mclk0) w_halt_n_nxt = 1'b1;
      end
      default: begin
        w_halt_n_nxt    = 1'b1;
        w_drive_ab_nxt  = 1'b0;
        w_dma_grant_nxt = 1'b0;
      end
    endcase
    // Sticky overrun: setting beats a coincident line_start clear.
    if (w_overrun_set)   w_overrun_nxt = 1'b1;
    else if (line_start) w_overrun_nxt = 1'b0;
    else                 w_overrun_nxt = r_overrun;
  end

  // Output and counter registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_halt_n     <= 1'b1;
      r_drive_ab   <= 1'b0;
      r_dma_grant  <= 1'b0;
      r_dma_cycles <= '0;
      r_overrun    <= 1'b0;
      r_settle_cnt <= '0;
    end else begin
      r_halt_n     <= w_halt_n_nxt;
      r_drive_ab   <= w_drive_ab_nxt;
      r_dma_grant  <= w_dma_grant_nxt;
      r_dma_cycles <= w_dma_cycles_nxt;
      r_overrun    <= w_overrun_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
    end
  end

  assign halt_n     = r_halt_n;
  assign drive_AB   = r_drive_ab;
  assign dma_grant  = r_dma_grant;
  assign dma_cycles = r_dma_cycles;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_maria_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_maria_dma_arbiter
// Brief    : Directed bench for maria_dma_arbiter. Every output change is
//            matched against the next queued expectation (value and cycle).
// Revision : 1.0 - initial release
// ============================================================================
module tb_maria_dma_arbiter;

  logic       clk_sys = 1'b0;
  logic       reset, mclk0, mclk1, pclk1, dma_en, line_start, dma_req, dma_done;
  logic       halt_n, drive_AB, dma_grant, overrun;
  logic [8:0] dma_cycles;

  typedef struct {
    logic [12:0] v;
    int          t;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  logic [12:0] prev   = 'x;
  logic [12:0] cur;
  exp_t        got;

  // Expected output model, updated by hand in the stimulus.
  logic       m_halt, m_drive, m_grant, m_ov;
  logic [8:0] m_cyc;

  maria_dma_arbiter #(
    .SETTLE_CYCLES (2),
    .MAX_DMA_CYCLES(400),
    .CNT_W         (9)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .mclk0     (mclk0),
    .mclk1     (mclk1),
    .pclk1     (pclk1),
    .dma_en    (dma_en),
    .line_start(line_start),
    .dma_req   (dma_req),
    .dma_done  (dma_done),
    .halt_n    (halt_n),
    .drive_AB  (drive_AB),
    .dma_grant (dma_grant),
    .dma_cycles(dma_cycles),
    .overrun   (overrun)
  );

  // Clock.
  always #5 clk_sys = ~clk_sys;

  // Edge counter used to time-stamp expectations.
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Monitor: any output change must match the oldest expectation.
  always @(negedge clk_sys) begin
    cur = {halt_n, drive_AB, dma_grant, overrun, dma_cycles};
    if (cur !== prev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: cyc=%0d actual=%h (no change expected)", cyc, cur);
      end else begin
        got = sb.pop_front();
        if (cur !== got.v || cyc != got.t) begin
          errors++;
          $display("FAIL %s: actual=%h at cyc %0d, required=%h at cyc %0d",
                   got.nm, cur, cyc, got.v, got.t);
        end
      end
      prev = cur;
    end
  end

  task automatic expect_out(input string nm);
    exp_t e;
    e.v  = {m_halt, m_drive, m_grant, m_ov, m_cyc};
    e.t  = cyc + 1;
    e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic clk1(input logic m0, input logic m1, input logic p1,
                      input logic dn, input logic ls);
    mclk0      = m0;
    mclk1      = m1;
    pclk1      = p1;
    dma_done   = dn;
    line_start = ls;
    @(negedge clk_sys);
  endtask

  // Request from IDLE through to grant; pclk1 on the request edge must be ignored.
  task automatic start_burst();
    dma_req = 1'b1;
    m_halt  = 1'b0;
    expect_out("req_halt");
    clk1(0, 0, 1, 0, 0);
    clk1(0, 0, 0, 0, 0);
    clk1(0, 0, 0, 0, 0);
    clk1(0, 0, 1, 0, 0);
    clk1(0, 1, 0, 0, 0);
    clk1(1, 0, 0, 0, 0);
    m_drive = 1'b1;
    m_grant = 1'b1;
    m_cyc   = 9'd0;
    expect_out("grant");
    clk1(0, 1, 0, 0, 0);
  endtask

  task automatic count_mclk1(input int n);
    for (int i = 0; i < n; i++) begin
      m_cyc = m_cyc + 9'd1;
      expect_out("dma_cycles");
      clk1(0, 1, 0, 0, 0);
      clk1(1, 0, 0, 0, 0);
    end
  endtask

  task automatic release_halt();
    m_halt = 1'b1;
    expect_out("halt_release");
    clk1(1, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; dma_en = 1'b1; dma_req = 1'b0;
    mclk0 = 1'b0; mclk1 = 1'b0; pclk1 = 1'b0; dma_done = 1'b0; line_start = 1'b0;
    m_halt = 1'b1; m_drive = 1'b0; m_grant = 1'b0; m_ov = 1'b0; m_cyc = 9'd0;
    expect_out("reset_state");
    clk1(0, 0, 0, 0, 0);
    clk1(0, 0, 0, 0, 0);
    reset = 1'b0;
    clk1(0, 0, 0, 0, 0);

    // Basic burst of 10; done coincides with mclk0, halt_n must wait for the next one.
    start_burst();
    count_mclk1(10);
    dma_req = 1'b0;
    m_drive = 1'b0; m_grant = 1'b0;
    expect_out("done_release");
    clk1(1, 0, 0, 1, 0);
    clk1(0, 0, 0, 0, 0);
    release_halt();
    clk1(0, 0, 0, 0, 0);

    // Budget overrun; line_start on the limit edge loses to the set.
    start_burst();
    count_mclk1(399);
    dma_req = 1'b0;
    m_cyc = 9'd400; m_drive = 1'b0; m_grant = 1'b0; m_ov = 1'b1;
    expect_out("budget_overrun");
    clk1(0, 1, 0, 0, 1);
    release_halt();
    clk1(0, 0, 0, 0, 0);
    clk1(0, 1, 0, 0, 0);
    m_ov = 1'b0;
    expect_out("overrun_clear");
    clk1(0, 0, 0, 0, 1);

    // dma_done on the 400th mclk1: normal release, no overrun.
    start_burst();
    count_mclk1(399);
    dma_req = 1'b0;
    m_cyc = 9'd400; m_drive = 1'b0; m_grant = 1'b0;
    expect_out("done_at_limit");
    clk1(0, 1, 0, 1, 0);
    release_halt();
    clk1(0, 0, 0, 0, 0);

    // Abort in HALT_REQ; later pclk1 is ignored.
    dma_req = 1'b1;
    m_halt  = 1'b0;
    expect_out("abort_halt");
    clk1(0, 0, 0, 0, 0);
    clk1(0, 0, 0, 0, 0);
    dma_req = 1'b0;
    clk1(0, 0, 0, 0, 0);
    clk1(0, 0, 1, 0, 0);
    release_halt();
    clk1(0, 0, 0, 0, 0);

    // dma_en drops during GRANT: immediate release.
    start_burst();
    count_mclk1(2);
    dma_en = 1'b0; dma_req = 1'b0;
    m_drive = 1'b0; m_grant = 1'b0;
    expect_out("en_drop_release");
    clk1(0, 0, 0, 0, 0);
    dma_en = 1'b1;
    clk1(0, 0, 0, 0, 0);
    release_halt();
    clk1(0, 0, 0, 0, 0);

    // Back-to-back: request held through RELEASE.
    start_burst();
    count_mclk1(2);
    m_drive = 1'b0; m_grant = 1'b0;
    expect_out("b2b_done");
    clk1(0, 0, 0, 1, 0);
    release_halt();
    m_halt = 1'b0;
    expect_out("b2b_rehalt");
    clk1(0, 0, 0, 0, 0);
    clk1(0, 0, 0, 0, 0);
    clk1(0, 0, 1, 0, 0);
    clk1(0, 1, 0, 0, 0);
    clk1(1, 0, 0, 0, 0);
    m_drive = 1'b1; m_grant = 1'b1; m_cyc = 9'd0;
    expect_out("b2b_grant");
    clk1(0, 1, 0, 0, 0);
    count_mclk1(1);

    // Reset mid-GRANT.
    reset = 1'b1;
    m_halt = 1'b1; m_drive = 1'b0; m_grant = 1'b0; m_cyc = 9'd0;
    expect_out("reset_mid_grant");
    clk1(0, 0, 0, 0, 0);
    reset = 1'b0; dma_req = 1'b0;
    clk1(0, 0, 0, 0, 0);
    dma_req = 1'b1;
    m_halt  = 1'b0;
    expect_out("post_reset_req");
    clk1(0, 0, 0, 0, 0);
    dma_req = 1'b0;
    clk1(0, 0, 0, 0, 0);
    release_halt();

    repeat (5) clk1(0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      got = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: no output change seen, required=%h at cyc %0d", got.nm, got.v, got.t);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
